// File: rtl/instruction_decode_pipe.sv
// Decode stage: classifies a 32-bit instruction, gathers operands (forwarding
// before register file) and holds micro-ops in an output register plus skid entry.
module instruction_decode_pipe #(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 4,
  parameter int FWD_PORTS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           instr_valid_i,
  input  logic [31:0]                    instr_i,
  output logic                           instr_ready_o,
  input  logic [3:0]                     flags_i,
  output logic [REG_IDX_W-1:0]           rr1_i_o,
  output logic [REG_IDX_W-1:0]           rr2_i_o,
  output logic [REG_IDX_W-1:0]           rr3_i_o,
  input  logic [DATA_W-1:0]              rr1_i,
  input  logic [DATA_W-1:0]              rr2_i,
  input  logic [DATA_W-1:0]              rr3_i,
  input  logic [FWD_PORTS-1:0]           fwd_valid_i,
  input  logic [FWD_PORTS*REG_IDX_W-1:0] fwd_dest_i,
  input  logic [FWD_PORTS*DATA_W-1:0]    fwd_data_i,
  input  logic                           flush_i,
  output logic                           uop_valid_o,
  input  logic                           uop_ready_i,
  output logic [2:0]                     uop_class_o,
  output logic                           uop_exec_o,
  output logic [3:0]                     uop_opcode_o,
  output logic [REG_IDX_W-1:0]           uop_dest_o,
  output logic [DATA_W-1:0]              uop_a_o,
  output logic [DATA_W-1:0]              uop_b_o,
  output logic [DATA_W-1:0]              uop_c_o,
  output logic                           uop_wr_dest_o,
  output logic                           uop_wr_cpsr_o
);

  localparam logic [2:0] CLS_NOP   = 3'd0;
  localparam logic [2:0] CLS_INT   = 3'd1;
  localparam logic [2:0] CLS_INTM  = 3'd2;
  localparam logic [2:0] CLS_LOAD  = 3'd3;
  localparam logic [2:0] CLS_STORE = 3'd4;
  localparam logic [2:0] CLS_UNDEF = 3'd7;

  typedef struct packed {
    logic [2:0]           cls;
    logic                 exec;
    logic [3:0]           opcode;
    logic [REG_IDX_W-1:0] dest;
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic [DATA_W-1:0]    c;
    logic                 wr_dest;
    logic                 wr_cpsr;
  } uop_t;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'h0:    pass = z;
      4'h1:    pass = !z;
      4'h2:    pass = c;
      4'h3:    pass = !c;
      4'h4:    pass = n;
      4'h5:    pass = !n;
      4'h6:    pass = v;
      4'h7:    pass = !v;
      4'h8:    pass = c && !z;
      4'h9:    pass = !c || z;
      4'hA:    pass = (n == v);
      4'hB:    pass = (n != v);
      4'hC:    pass = !z && (n == v);
      4'hD:    pass = z || (n != v);
      4'hE:    pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  function automatic logic [REG_IDX_W-1:0] to_idx(input logic [3:0] field);
    return REG_IDX_W'(field);
  endfunction

  function automatic logic [DATA_W-1:0] rot_imm(input logic [7:0] imm8, input logic [3:0] rot);
    logic [2*DATA_W-1:0] dbl;
    logic [31:0]         amt;
    amt = (32'(rot) * 32'd2) % 32'(DATA_W);
    dbl = {DATA_W'(imm8), DATA_W'(imm8)} >> amt;
    return dbl[DATA_W-1:0];
  endfunction

  // Lowest-index matching forwarding port overrides the register file value.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [REG_IDX_W-1:0]           idx,
    input logic [DATA_W-1:0]              rf_data,
    input logic [FWD_PORTS-1:0]           fv,
    input logic [FWD_PORTS*REG_IDX_W-1:0] fd,
    input logic [FWD_PORTS*DATA_W-1:0]    fdat
  );
    logic [DATA_W-1:0] val;
    val = rf_data;
    for (int p = FWD_PORTS - 1; p >= 0; p--) begin
      if (fv[p] && (fd[p*REG_IDX_W +: REG_IDX_W] == idx)) val = fdat[p*DATA_W +: DATA_W];
    end
    return val;
  endfunction

  logic                 w_is_mul;
  logic [2:0]           w_cls;
  logic [REG_IDX_W-1:0] w_rr1, w_rr2, w_rr3;
  uop_t                 w_dec, w_uop;
  uop_t                 r_out, r_skid, w_out_nxt, w_skid_nxt;
  logic                 r_out_v, r_skid_v, r_ready;
  logic                 w_out_v_nxt, w_skid_v_nxt;
  logic                 w_accept, w_out_fire;

  assign w_is_mul = !instr_i[25] && instr_i[7] && instr_i[4];

  // Classify the instruction and derive register indices and non-operand fields.
  always_comb begin
    w_dec = '0;
    w_rr1 = '0;
    w_rr2 = '0;
    w_rr3 = '0;
    if (instr_i[27:0] == 28'h320F000)                 w_cls = CLS_NOP;
    else if ((instr_i[27:26] == 2'b00) && !w_is_mul)  w_cls = CLS_INT;
    else if (w_is_mul)                                w_cls = CLS_INTM;
    else if (instr_i[27:25] == 3'b011)                w_cls = instr_i[20] ? CLS_LOAD : CLS_STORE;
    else                                              w_cls = CLS_UNDEF;
    w_dec.cls = w_cls;
    case (w_cls)
      CLS_INT: begin
        w_rr1          = to_idx(instr_i[19:16]);
        w_rr2          = instr_i[25] ? '0 : to_idx(instr_i[3:0]);
        w_dec.exec     = cond_pass(instr_i[31:28], flags_i);
        w_dec.opcode   = instr_i[24:21];
        w_dec.dest     = to_idx(instr_i[15:12]);
        // Opcodes 8..11 are compare-only: flags written, no destination.
        if (instr_i[24:23] == 2'b10) begin
          w_dec.wr_dest = 1'b0;
          w_dec.wr_cpsr = 1'b1;
        end else begin
          w_dec.wr_dest = 1'b1;
          w_dec.wr_cpsr = instr_i[20];
        end
      end
      CLS_INTM: begin
        w_rr1          = to_idx(instr_i[3:0]);
        w_rr2          = to_idx(instr_i[11:8]);
        w_rr3          = to_idx(instr_i[15:12]);
        w_dec.exec     = cond_pass(instr_i[31:28], flags_i);
        w_dec.opcode   = {1'b0, instr_i[23:21]};
        w_dec.dest     = to_idx(instr_i[19:16]);
        w_dec.wr_dest  = 1'b1;
      end
      CLS_LOAD, CLS_STORE: begin
        w_rr1          = to_idx(instr_i[19:16]);
        w_rr3          = to_idx(instr_i[15:12]);
        w_dec.exec     = cond_pass(instr_i[31:28], flags_i);
        w_dec.dest     = to_idx(instr_i[15:12]);
        w_dec.wr_dest  = (w_cls == CLS_LOAD);
      end
      default: w_dec.cls = w_cls;
    endcase
  end

  assign rr1_i_o = w_rr1;
  assign rr2_i_o = w_rr2;
  assign rr3_i_o = w_rr3;

  // Fill operand slots from forwarding buses, register file data or immediates.
  always_comb begin
    w_uop = w_dec;
    case (w_dec.cls)
      CLS_INT: begin
        w_uop.a = pick_operand(w_rr1, rr1_i, fwd_valid_i, fwd_dest_i, fwd_data_i);
        w_uop.b = instr_i[25] ? rot_imm(instr_i[7:0], instr_i[11:8])
                              : pick_operand(w_rr2, rr2_i, fwd_valid_i, fwd_dest_i, fwd_data_i);
      end
      CLS_INTM: begin
        w_uop.a = pick_operand(w_rr1, rr1_i, fwd_valid_i, fwd_dest_i, fwd_data_i);
        w_uop.b = pick_operand(w_rr2, rr2_i, fwd_valid_i, fwd_dest_i, fwd_data_i);
        w_uop.c = pick_operand(w_rr3, rr3_i, fwd_valid_i, fwd_dest_i, fwd_data_i);
      end
      CLS_LOAD, CLS_STORE: begin
        w_uop.a = pick_operand(w_rr1, rr1_i, fwd_valid_i, fwd_dest_i, fwd_data_i);
        w_uop.b = DATA_W'(instr_i[11:0]);
        w_uop.c = pick_operand(w_rr3, rr3_i, fwd_valid_i, fwd_dest_i, fwd_data_i);
      end
      default: w_uop = w_dec;
    endcase
  end

  assign w_accept   = instr_valid_i && r_ready && !flush_i;
  assign w_out_fire = r_out_v && uop_ready_i;

  // Buffer next state; the skid entry only fills while the output register stalls.
  always_comb begin
    w_out_v_nxt  = r_out_v;
    w_out_nxt    = r_out;
    w_skid_v_nxt = r_skid_v;
    w_skid_nxt   = r_skid;
    if (flush_i) begin
      w_out_v_nxt  = 1'b0;
      w_out_nxt    = '0;
      w_skid_v_nxt = 1'b0;
      w_skid_nxt   = '0;
    end else if (!r_out_v || w_out_fire) begin
      if (r_skid_v) begin
        w_out_v_nxt  = 1'b1;
        w_out_nxt    = r_skid;
        w_skid_v_nxt = 1'b0;
        w_skid_nxt   = '0;
      end else if (w_accept) begin
        w_out_v_nxt  = 1'b1;
        w_out_nxt    = w_uop;
      end else begin
        w_out_v_nxt  = 1'b0;
        w_out_nxt    = '0;
      end
    end else begin
      if (w_accept) begin
        w_skid_v_nxt = 1'b1;
        w_skid_nxt   = w_uop;
      end else begin
        w_skid_v_nxt = r_skid_v;
      end
    end
  end

  // Buffer registers and registered ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_v  <= 1'b0;
      r_out    <= '0;
      r_skid_v <= 1'b0;
      r_skid   <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_out_v  <= w_out_v_nxt;
      r_out    <= w_out_nxt;
      r_skid_v <= w_skid_v_nxt;
      r_skid   <= w_skid_nxt;
      r_ready  <= !w_skid_v_nxt;
    end
  end

  assign instr_ready_o = r_ready;
  assign uop_valid_o   = r_out_v;
  assign uop_class_o   = r_out.cls;
  assign uop_exec_o    = r_out.exec;
  assign uop_opcode_o  = r_out.opcode;
  assign uop_dest_o    = r_out.dest;
  assign uop_a_o       = r_out.a;
  assign uop_b_o       = r_out.b;
  assign uop_c_o       = r_out.c;
  assign uop_wr_dest_o = r_out.wr_dest;
  assign uop_wr_cpsr_o = r_out.wr_cpsr;

endmodule
